mac_seq_ctrl: RTL



---
 rtl/mac_seq_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: splits a command into MAX_MACS-wide chunks, streams them
// from the operand buffer into the shared mac unit and accumulates the partial sums.
module mac_seq_ctrl #(
   parameter  int MAX_MACS   = 64,
   parameter  int DATA_WIDTH = 8,
   parameter  int LEN_WIDTH  = 12,
   parameter  int ADDR_WIDTH = 8,
   parameter  int ACC_WIDTH  = 32,
   localparam int NW         = $clog2(MAX_MACS+1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [LEN_WIDTH-1:0]           cmd_len,
   input  logic [ADDR_WIDTH-1:0]          cmd_base,
   output logic                           buf_rd_en,
   output logic [ADDR_WIDTH-1:0]          buf_rd_addr,
   input  logic [MAX_MACS*DATA_WIDTH-1:0] buf_rd_data,
   input  logic [MAX_MACS*DATA_WIDTH-1:0] buf_rd_weight,
   output logic                           mac_valid_in,
   output logic [NW-1:0]                  mac_num_macs,
   output logic [MAX_MACS*DATA_WIDTH-1:0] mac_data,
   output logic [MAX_MACS*DATA_WIDTH-1:0] mac_weight,
   input  logic signed [2*DATA_WIDTH-1:0] mac_out,
   input  logic                           mac_valid_out,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic signed [ACC_WIDTH-1:0]    res_data,
   output logic                           busy
);

   typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, DONE} state_t;

   localparam logic [LEN_WIDTH-1:0] FULL_LEN = LEN_WIDTH'(MAX_MACS);

   state_t                       state;
   logic [LEN_WIDTH-1:0]         rem_q;
   logic [NW-1:0]                rd_size;
   logic [LEN_WIDTH-1:0]         issued_cnt;
   logic [LEN_WIDTH-1:0]         returned_cnt;
   logic signed [ACC_WIDTH-1:0]  acc;

   logic                         accum_en;
   logic                         issue_nxt;
   logic [NW-1:0]                cur_size;
   logic [NW-1:0]                first_size;
   logic [LEN_WIDTH-1:0]         ret_next;
   logic signed [ACC_WIDTH-1:0]  acc_next;

   function automatic logic [NW-1:0] chunk_of(input logic [LEN_WIDTH-1:0] r);
      return (r >= FULL_LEN) ? NW'(MAX_MACS) : NW'(r);
   endfunction

   assign mac_data   = buf_rd_data;
   assign mac_weight = buf_rd_weight;
   assign cmd_ready  = (state == IDLE);
   assign busy       = (state != IDLE);

   // Returns arriving in IDLE/DONE are stale (in flight across a reset) and dropped.
   always_comb begin
      accum_en   = mac_valid_out && (state == ISSUE || state == GAP || state == DRAIN);
      cur_size   = chunk_of(rem_q);
      first_size = chunk_of(cmd_len);
      issue_nxt  = (state == GAP) || (state == ISSUE && rem_q >= FULL_LEN);
      ret_next   = returned_cnt + (accum_en ? LEN_WIDTH'(1) : LEN_WIDTH'(0));
      acc_next   = accum_en ? acc + ACC_WIDTH'(mac_out) : acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rem_q        <= '0;
         rd_size      <= '0;
         issued_cnt   <= '0;
         returned_cnt <= '0;
         acc          <= '0;
         buf_rd_en    <= 1'b0;
         buf_rd_addr  <= '0;
         mac_valid_in <= 1'b0;
         mac_num_macs <= '0;
         res_valid    <= 1'b0;
         res_data     <= '0;
      end else begin
         mac_valid_in <= buf_rd_en;
         // Size only moves together with a new issue so mac sees it stable.
         if (buf_rd_en)
            mac_num_macs <= rd_size;
         acc          <= acc_next;
         returned_cnt <= ret_next;
         buf_rd_en    <= 1'b0;

         if (issue_nxt) begin
            state       <= ISSUE;
            buf_rd_en   <= 1'b1;
            buf_rd_addr <= buf_rd_addr + ADDR_WIDTH'(1);
            rd_size     <= cur_size;
            rem_q       <= rem_q - LEN_WIDTH'(cur_size);
            issued_cnt  <= issued_cnt + LEN_WIDTH'(1);
         end

         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  acc          <= '0;
                  returned_cnt <= '0;
                  if (cmd_len == '0) begin
                     state      <= DONE;
                     issued_cnt <= '0;
                     res_valid  <= 1'b1;
                     res_data   <= '0;
                  end else begin
                     state       <= ISSUE;
                     buf_rd_en   <= 1'b1;
                     buf_rd_addr <= cmd_base;
                     rd_size     <= first_size;
                     rem_q       <= cmd_len - LEN_WIDTH'(first_size);
                     issued_cnt  <= LEN_WIDTH'(1);
                  end
               end
            end
            ISSUE: begin
               // A short final chunk gets one idle cycle so its size never
               // overlaps the previous chunk's reduction.
               if (rem_q == '0)
                  state <= DRAIN;
               else if (rem_q < FULL_LEN)
                  state <= GAP;
            end
            DRAIN: begin
               if (ret_next == issued_cnt) begin
                  state     <= DONE;
                  res_valid <= 1'b1;
                  res_data  <= acc_next;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
